// File: rtl/axi_shim_arbiter_if.sv
// Bundle of per-requester command/response signals and the single axi_shim request port.
// The master modport is the arbiter's view; slave is the view of the environment around it.
interface axi_shim_arbiter_if #(
    parameter int unsigned NumPorts     = 3,
    parameter int unsigned AxiNumWords  = 4,
    parameter int unsigned AxiUserWidth = 64,
    parameter int unsigned AxiIdWidth   = 4
);
    localparam int unsigned BlenW = (AxiNumWords > 2) ? $clog2(AxiNumWords) : 1;

    // requester side, read channel
    logic [NumPorts-1:0]    p_rd_req;
    logic [NumPorts-1:0]    p_rd_gnt;
    logic [63:0]            p_rd_addr [NumPorts];
    logic [BlenW-1:0]       p_rd_blen [NumPorts];
    logic [1:0]             p_rd_size [NumPorts];
    logic [NumPorts-1:0]    p_rd_lock;
    logic [NumPorts-1:0]    p_rd_valid;
    logic [NumPorts-1:0]    p_rd_rdy;
    logic                   p_rd_last;
    logic                   p_rd_exokay;
    logic [63:0]            p_rd_data;
    logic [AxiUserWidth-1:0] p_rd_user;

    // requester side, write channel
    logic [NumPorts-1:0]    p_wr_req;
    logic [NumPorts-1:0]    p_wr_gnt;
    logic [63:0]            p_wr_addr [NumPorts];
    logic [AxiNumWords-1:0][63:0]           p_wr_data [NumPorts];
    logic [AxiNumWords-1:0][AxiUserWidth-1:0] p_wr_user [NumPorts];
    logic [AxiNumWords-1:0][7:0]            p_wr_be [NumPorts];
    logic [BlenW-1:0]       p_wr_blen [NumPorts];
    logic [1:0]             p_wr_size [NumPorts];
    logic [NumPorts-1:0]    p_wr_lock;
    logic [5:0]             p_wr_atop [NumPorts];
    logic [NumPorts-1:0]    p_wr_valid;
    logic [NumPorts-1:0]    p_wr_rdy;
    logic                   p_wr_exokay;

    // shim side, read channel
    logic                   shim_rd_req;
    logic [63:0]            shim_rd_addr;
    logic [BlenW-1:0]       shim_rd_blen;
    logic [1:0]             shim_rd_size;
    logic [AxiIdWidth-1:0]  shim_rd_id;
    logic                   shim_rd_lock;
    logic                   shim_rd_rdy;
    logic                   shim_rd_gnt;
    logic                   shim_rd_valid;
    logic                   shim_rd_last;
    logic [63:0]            shim_rd_data;
    logic [AxiUserWidth-1:0] shim_rd_user;
    logic [AxiIdWidth-1:0]  shim_rd_rsp_id;
    logic                   shim_rd_exokay;

    // shim side, write channel
    logic                   shim_wr_req;
    logic [63:0]            shim_wr_addr;
    logic [AxiNumWords-1:0][63:0]           shim_wr_data;
    logic [AxiNumWords-1:0][AxiUserWidth-1:0] shim_wr_user;
    logic [AxiNumWords-1:0][7:0]            shim_wr_be;
    logic [BlenW-1:0]       shim_wr_blen;
    logic [1:0]             shim_wr_size;
    logic [AxiIdWidth-1:0]  shim_wr_id;
    logic                   shim_wr_lock;
    logic [5:0]             shim_wr_atop;
    logic                   shim_wr_rdy;
    logic                   shim_wr_gnt;
    logic                   shim_wr_valid;
    logic [AxiIdWidth-1:0]  shim_wr_rsp_id;
    logic                   shim_wr_exokay;

    modport master (
        input  p_rd_req, p_rd_addr, p_rd_blen, p_rd_size, p_rd_lock, p_rd_rdy,
        output p_rd_gnt, p_rd_valid, p_rd_last, p_rd_exokay, p_rd_data, p_rd_user,
        input  p_wr_req, p_wr_addr, p_wr_data, p_wr_user, p_wr_be, p_wr_blen,
               p_wr_size, p_wr_lock, p_wr_atop, p_wr_rdy,
        output p_wr_gnt, p_wr_valid, p_wr_exokay,
        output shim_rd_req, shim_rd_addr, shim_rd_blen, shim_rd_size, shim_rd_id,
               shim_rd_lock, shim_rd_rdy,
        input  shim_rd_gnt, shim_rd_valid, shim_rd_last, shim_rd_data, shim_rd_user,
               shim_rd_rsp_id, shim_rd_exokay,
        output shim_wr_req, shim_wr_addr, shim_wr_data, shim_wr_user, shim_wr_be,
               shim_wr_blen, shim_wr_size, shim_wr_id, shim_wr_lock, shim_wr_atop,
               shim_wr_rdy,
        input  shim_wr_gnt, shim_wr_valid, shim_wr_rsp_id, shim_wr_exokay
    );

    modport slave (
        output p_rd_req, p_rd_addr, p_rd_blen, p_rd_size, p_rd_lock, p_rd_rdy,
        input  p_rd_gnt, p_rd_valid, p_rd_last, p_rd_exokay, p_rd_data, p_rd_user,
        output p_wr_req, p_wr_addr, p_wr_data, p_wr_user, p_wr_be, p_wr_blen,
               p_wr_size, p_wr_lock, p_wr_atop, p_wr_rdy,
        input  p_wr_gnt, p_wr_valid, p_wr_exokay,
        input  shim_rd_req, shim_rd_addr, shim_rd_blen, shim_rd_size, shim_rd_id,
               shim_rd_lock, shim_rd_rdy,
        output shim_rd_gnt, shim_rd_valid, shim_rd_last, shim_rd_data, shim_rd_user,
               shim_rd_rsp_id, shim_rd_exokay,
        input  shim_wr_req, shim_wr_addr, shim_wr_data, shim_wr_user, shim_wr_be,
               shim_wr_blen, shim_wr_size, shim_wr_id, shim_wr_lock, shim_wr_atop,
               shim_wr_rdy,
        output shim_wr_gnt, shim_wr_valid, shim_wr_rsp_id, shim_wr_exokay
    );
endinterface

// File: rtl/axi_shim_arbiter.sv
// Round-robin sharing of one axi_shim request port between NumPorts requesters,
// with independent read/write arbiters and ID-based response routing.

module axi_shim_arbiter_rr #(
    parameter int unsigned NumPorts = 3,
    localparam int unsigned IdxW    = $clog2(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] req,
    input  logic                shim_gnt,
    output logic                shim_req,
    output logic [IdxW-1:0]     sel,
    output logic [NumPorts-1:0] gnt
);
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e          state_reg, state_next;
    logic [IdxW-1:0] sel_reg, sel_next;
    logic [IdxW-1:0] rr_reg, rr_next;
    logic [IdxW-1:0] winner, scan_idx;
    logic            any_req;

    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] v);
        return (v == IdxW'(NumPorts - 1)) ? '0 : v + IdxW'(1);
    endfunction

    // First requester at or after the round-robin pointer; defaults to port 0.
    always_comb begin
        winner   = '0;
        any_req  = 1'b0;
        scan_idx = rr_reg;
        for (int k = 0; k < NumPorts; k++) begin
            if (!any_req && req[scan_idx]) begin
                winner  = scan_idx;
                any_req = 1'b1;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        rr_next    = rr_reg;
        gnt        = '0;
        shim_req   = 1'b0;
        sel        = winner;
        case (state_reg)
            IDLE: begin
                shim_req = any_req;
                if (any_req) begin
                    if (shim_gnt) begin
                        gnt[winner] = 1'b1;
                        rr_next     = wrap_inc(winner);
                    end else begin
                        sel_next   = winner;
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // Selection frozen: the shim walks burst words of the muxed inputs until it grants.
                sel      = sel_reg;
                shim_req = 1'b1;
                if (shim_gnt) begin
                    gnt[sel_reg] = 1'b1;
                    rr_next      = wrap_inc(sel_reg);
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            rr_reg    <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            rr_reg    <= rr_next;
        end
    end
endmodule

module axi_shim_arbiter #(
    parameter int unsigned NumPorts     = 3,
    parameter int unsigned AxiNumWords  = 4,
    parameter int unsigned AxiUserWidth = 64,
    parameter int unsigned AxiIdWidth   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    axi_shim_arbiter_if.master bus
);
    localparam int unsigned IdxW = $clog2(NumPorts);

    logic [IdxW-1:0]     rd_sel, wr_sel;
    logic                rd_shim_req, wr_shim_req;
    logic [NumPorts-1:0] rd_gnt, wr_gnt;

    axi_shim_arbiter_rr #(.NumPorts(NumPorts)) u_rd_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req      (bus.p_rd_req),
        .shim_gnt (bus.shim_rd_gnt),
        .shim_req (rd_shim_req),
        .sel      (rd_sel),
        .gnt      (rd_gnt)
    );

    axi_shim_arbiter_rr #(.NumPorts(NumPorts)) u_wr_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req      (bus.p_wr_req),
        .shim_gnt (bus.shim_wr_gnt),
        .shim_req (wr_shim_req),
        .sel      (wr_sel),
        .gnt      (wr_gnt)
    );

    assign bus.shim_rd_req = rd_shim_req;
    assign bus.shim_wr_req = wr_shim_req;
    assign bus.p_rd_gnt    = rd_gnt;
    assign bus.p_wr_gnt    = wr_gnt;
    // Requester index doubles as the AXI ID so responses can be routed back.
    assign bus.shim_rd_id  = AxiIdWidth'(rd_sel);
    assign bus.shim_wr_id  = AxiIdWidth'(wr_sel);

    always_comb begin
        bus.shim_rd_addr = bus.p_rd_addr[0];
        bus.shim_rd_blen = bus.p_rd_blen[0];
        bus.shim_rd_size = bus.p_rd_size[0];
        bus.shim_rd_lock = bus.p_rd_lock[0];
        for (int i = 1; i < NumPorts; i++) begin
            if (rd_sel == IdxW'(i)) begin
                bus.shim_rd_addr = bus.p_rd_addr[i];
                bus.shim_rd_blen = bus.p_rd_blen[i];
                bus.shim_rd_size = bus.p_rd_size[i];
                bus.shim_rd_lock = bus.p_rd_lock[i];
            end
        end
    end

    always_comb begin
        bus.shim_wr_addr = bus.p_wr_addr[0];
        bus.shim_wr_data = bus.p_wr_data[0];
        bus.shim_wr_user = bus.p_wr_user[0];
        bus.shim_wr_be   = bus.p_wr_be[0];
        bus.shim_wr_blen = bus.p_wr_blen[0];
        bus.shim_wr_size = bus.p_wr_size[0];
        bus.shim_wr_lock = bus.p_wr_lock[0];
        bus.shim_wr_atop = bus.p_wr_atop[0];
        for (int i = 1; i < NumPorts; i++) begin
            if (wr_sel == IdxW'(i)) begin
                bus.shim_wr_addr = bus.p_wr_addr[i];
                bus.shim_wr_data = bus.p_wr_data[i];
                bus.shim_wr_user = bus.p_wr_user[i];
                bus.shim_wr_be   = bus.p_wr_be[i];
                bus.shim_wr_blen = bus.p_wr_blen[i];
                bus.shim_wr_size = bus.p_wr_size[i];
                bus.shim_wr_lock = bus.p_wr_lock[i];
                bus.shim_wr_atop = bus.p_wr_atop[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_route
            assign bus.p_rd_valid[gi] = bus.shim_rd_valid && (bus.shim_rd_rsp_id == AxiIdWidth'(gi));
            assign bus.p_wr_valid[gi] = bus.shim_wr_valid && (bus.shim_wr_rsp_id == AxiIdWidth'(gi));
        end
    endgenerate

    // IDs that match no requester are accepted unconditionally so they drain.
    always_comb begin
        bus.shim_rd_rdy = 1'b1;
        bus.shim_wr_rdy = 1'b1;
        for (int i = 0; i < NumPorts; i++) begin
            if (bus.shim_rd_rsp_id == AxiIdWidth'(i)) bus.shim_rd_rdy = bus.p_rd_rdy[i];
            if (bus.shim_wr_rsp_id == AxiIdWidth'(i)) bus.shim_wr_rdy = bus.p_wr_rdy[i];
        end
    end

    assign bus.p_rd_last   = bus.shim_rd_last;
    assign bus.p_rd_exokay = bus.shim_rd_exokay;
    assign bus.p_rd_data   = bus.shim_rd_data;
    assign bus.p_rd_user   = bus.shim_rd_user;
    assign bus.p_wr_exokay = bus.shim_wr_exokay;
endmodule

// File: tb/tb_axi_shim_arbiter.sv
// Scoreboard bench for axi_shim_arbiter: expected grants and routed responses are queued
// when stimulus is driven and compared when the DUT outputs are sampled after the drive edge.
module tb_axi_shim_arbiter;
    localparam int NP = 3;
    localparam int NW = 4;
    localparam int UW = 64;
    localparam int IW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_shim_arbiter_if #(.NumPorts(NP), .AxiNumWords(NW), .AxiUserWidth(UW), .AxiIdWidth(IW)) bus ();

    axi_shim_arbiter #(.NumPorts(NP), .AxiNumWords(NW), .AxiUserWidth(UW), .AxiIdWidth(IW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [2:0]  valid;
        logic        rdy;
        logic [63:0] data;
    } rsp_t;

    int   checks = 0;
    int   fails  = 0;
    int   exp_rd_q[$];
    int   exp_wr_q[$];
    rsp_t rsp_q[$];
    rsp_t rsp_exp;
    logic [2:0] exp_gnt;
    logic [NW-1:0][63:0] data0, data2;

    // response stimulus tables: id, per-port ready, expected valid vector, expected shim ready
    localparam logic [3:0] RD_ID  [6] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd7, 4'd0};
    localparam logic [2:0] RD_RDY [6] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b010};
    localparam logic [2:0] RD_EV  [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
    localparam logic       RD_ER  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [3:0] WR_ID  [3] = '{4'd1, 4'd3, 4'd2};
    localparam logic [2:0] WR_RDY [3] = '{3'b010, 3'b000, 3'b000};
    localparam logic [2:0] WR_EV  [3] = '{3'b010, 3'b000, 3'b100};
    localparam logic       WR_ER  [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic init_inputs();
        bus.p_rd_req = '0; bus.p_rd_lock = '0; bus.p_rd_rdy = '0;
        bus.p_wr_req = '0; bus.p_wr_lock = '0; bus.p_wr_rdy = '0;
        for (int i = 0; i < NP; i++) begin
            bus.p_rd_addr[i] = '0; bus.p_rd_blen[i] = '0; bus.p_rd_size[i] = '0;
            bus.p_wr_addr[i] = 64'h1000_0000 + 64'(i) * 64'h100;
            bus.p_wr_data[i] = '0; bus.p_wr_user[i] = '0; bus.p_wr_be[i] = '1;
            bus.p_wr_blen[i] = '0; bus.p_wr_size[i] = 2'd3; bus.p_wr_atop[i] = '0;
        end
        bus.shim_rd_gnt = 1'b0; bus.shim_rd_valid = 1'b0; bus.shim_rd_last = 1'b0;
        bus.shim_rd_data = '0; bus.shim_rd_user = '0; bus.shim_rd_rsp_id = '0;
        bus.shim_rd_exokay = 1'b0;
        bus.shim_wr_gnt = 1'b0; bus.shim_wr_valid = 1'b0; bus.shim_wr_rsp_id = '0;
        bus.shim_wr_exokay = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.p_rd_gnt, bus.p_wr_gnt, bus.p_rd_valid, bus.p_wr_valid,
                 bus.shim_rd_req, bus.shim_wr_req} !== 14'd0) begin
                fails++;
                $display("FAIL reset_idle: got %b expected 0", {bus.p_rd_gnt, bus.p_wr_gnt,
                         bus.p_rd_valid, bus.p_wr_valid, bus.shim_rd_req, bus.shim_wr_req});
            end
        end
        $display("reset idle: 5 cycles observed");
    endtask

    task automatic test_single_read();
        @(negedge clk);
        bus.p_rd_req     = 3'b010;
        bus.p_rd_addr[1] = 64'h8000_0040;
        bus.p_rd_blen[1] = 2'd3;
        bus.p_rd_size[1] = 2'd3;
        bus.shim_rd_gnt  = 1'b1;
        exp_rd_q.push_back(1);
        #1;
        checks++;
        if (bus.shim_rd_req !== 1'b1) begin
            fails++; $display("FAIL rd_req: got %b expected 1", bus.shim_rd_req);
        end
        checks++;
        if (bus.shim_rd_id !== 4'd1) begin
            fails++; $display("FAIL rd_id: got %0d expected 1", bus.shim_rd_id);
        end
        checks++;
        if (bus.shim_rd_addr !== 64'h8000_0040) begin
            fails++; $display("FAIL rd_addr: got %h expected 80000040", bus.shim_rd_addr);
        end
        checks++;
        if (bus.shim_rd_blen !== 2'd3) begin
            fails++; $display("FAIL rd_blen: got %0d expected 3", bus.shim_rd_blen);
        end
        exp_gnt = (exp_rd_q.size() != 0) ? 3'(1 << exp_rd_q.pop_front()) : 3'b111;
        checks++;
        if (bus.p_rd_gnt !== exp_gnt) begin
            fails++; $display("FAIL rd_gnt_immediate: got %b expected %b", bus.p_rd_gnt, exp_gnt);
        end
        checks++;
        if (bus.p_wr_gnt !== 3'b000) begin
            fails++; $display("FAIL wr_gnt_quiet: got %b expected 000", bus.p_wr_gnt);
        end
        $display("read grant: port 1 addr %h", bus.shim_rd_addr);
        @(negedge clk);
        bus.p_rd_req    = '0;
        bus.shim_rd_gnt = 1'b0;
    endtask

    task automatic test_rr_writes();
        int p;
        @(negedge clk);
        bus.p_wr_req = 3'b111;
        exp_wr_q.push_back(0); exp_wr_q.push_back(1);
        exp_wr_q.push_back(2); exp_wr_q.push_back(0);
        for (int g = 0; g < 4; g++) begin
            bus.shim_wr_gnt = 1'b0;
            #1;
            checks++;
            if (bus.p_wr_gnt !== 3'b000 || bus.shim_wr_req !== 1'b1) begin
                fails++;
                $display("FAIL rr_wait: got gnt=%b req=%b expected gnt=000 req=1",
                         bus.p_wr_gnt, bus.shim_wr_req);
            end
            @(negedge clk);
            bus.shim_wr_gnt = 1'b1;
            #1;
            p = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 7;
            exp_gnt = (p < NP) ? 3'(1 << p) : 3'b111;
            checks++;
            if (bus.p_wr_gnt !== exp_gnt) begin
                fails++; $display("FAIL rr_gnt: got %b expected %b", bus.p_wr_gnt, exp_gnt);
            end
            checks++;
            if (bus.shim_wr_id !== 4'(p) || bus.shim_wr_addr !== 64'h1000_0000 + 64'(p) * 64'h100) begin
                fails++;
                $display("FAIL rr_cmd: got id=%0d addr=%h expected id=%0d", bus.shim_wr_id,
                         bus.shim_wr_addr, p);
            end
            $display("write grant: port %0d id %0d", p, bus.shim_wr_id);
            @(negedge clk);
        end
        bus.p_wr_req    = '0;
        bus.shim_wr_gnt = 1'b0;
    endtask

    task automatic test_locked_burst();
        for (int w = 0; w < NW; w++) begin
            data0[w] = 64'hA0A0_0000_0000_0000 + 64'(w);
            data2[w] = 64'hC2C2_0000_0000_0000 + 64'(w);
        end
        @(negedge clk);
        bus.p_wr_data[0] = data0;
        bus.p_wr_data[2] = data2;
        bus.p_wr_blen[0] = 2'd3;
        bus.p_wr_req     = 3'b001;
        bus.shim_wr_gnt  = 1'b0;
        exp_wr_q.push_back(0);
        exp_wr_q.push_back(2);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) bus.p_wr_req[2] = 1'b1;
            #1;
            checks++;
            if (bus.shim_wr_data !== data0 || bus.shim_wr_id !== 4'd0 || bus.p_wr_gnt !== 3'b000) begin
                fails++;
                $display("FAIL burst_hold: got data=%h id=%0d gnt=%b expected data=%h id=0 gnt=000",
                         bus.shim_wr_data, bus.shim_wr_id, bus.p_wr_gnt, data0);
            end
            @(negedge clk);
        end
        bus.shim_wr_gnt = 1'b1;
        #1;
        exp_gnt = (exp_wr_q.size() != 0) ? 3'(1 << exp_wr_q.pop_front()) : 3'b111;
        checks++;
        if (bus.p_wr_gnt !== exp_gnt || bus.shim_wr_data !== data0) begin
            fails++;
            $display("FAIL burst_gnt: got gnt=%b data=%h expected gnt=%b", bus.p_wr_gnt,
                     bus.shim_wr_data, exp_gnt);
        end
        $display("write grant: burst port 0 after 6 stalled cycles");
        @(negedge clk);
        bus.p_wr_req[0] = 1'b0;
        bus.shim_wr_gnt = 1'b0;
        #1;
        checks++;
        if (bus.shim_wr_id !== 4'd2 || bus.shim_wr_data !== data2 || bus.p_wr_gnt !== 3'b000) begin
            fails++;
            $display("FAIL burst_next: got id=%0d data=%h gnt=%b expected id=2", bus.shim_wr_id,
                     bus.shim_wr_data, bus.p_wr_gnt);
        end
        @(negedge clk);
        bus.shim_wr_gnt = 1'b1;
        #1;
        exp_gnt = (exp_wr_q.size() != 0) ? 3'(1 << exp_wr_q.pop_front()) : 3'b111;
        checks++;
        if (bus.p_wr_gnt !== exp_gnt || bus.shim_wr_id !== 4'd2) begin
            fails++;
            $display("FAIL burst_next_gnt: got gnt=%b id=%0d expected gnt=%b id=2", bus.p_wr_gnt,
                     bus.shim_wr_id, exp_gnt);
        end
        $display("write grant: port 2 id %0d", bus.shim_wr_id);
        @(negedge clk);
        bus.p_wr_req    = '0;
        bus.shim_wr_gnt = 1'b0;
    endtask

    task automatic test_read_routing();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.shim_rd_valid  = 1'b1;
            bus.shim_rd_rsp_id = RD_ID[c];
            bus.shim_rd_data   = 64'hD000_0000_0000_0000 + 64'(c);
            bus.shim_rd_user   = 64'(c) << 8;
            bus.shim_rd_last   = (c == 5);
            bus.shim_rd_exokay = c[0];
            bus.p_rd_rdy       = RD_RDY[c];
            rsp_q.push_back('{valid: RD_EV[c], rdy: RD_ER[c], data: 64'hD000_0000_0000_0000 + 64'(c)});
            #1;
            rsp_exp = (rsp_q.size() != 0) ? rsp_q.pop_front() : '1;
            checks++;
            if (bus.p_rd_valid !== rsp_exp.valid || bus.shim_rd_rdy !== rsp_exp.rdy ||
                bus.p_rd_data !== rsp_exp.data || bus.p_rd_last !== (c == 5)) begin
                fails++;
                $display("FAIL rd_route: got valid=%b rdy=%b data=%h last=%b expected valid=%b rdy=%b data=%h",
                         bus.p_rd_valid, bus.shim_rd_rdy, bus.p_rd_data, bus.p_rd_last,
                         rsp_exp.valid, rsp_exp.rdy, rsp_exp.data);
            end
            $display("R beat: id %0d valid %b rdy %b", RD_ID[c], bus.p_rd_valid, bus.shim_rd_rdy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.shim_rd_valid  = 1'b0;
            bus.shim_wr_valid  = 1'b1;
            bus.shim_wr_rsp_id = WR_ID[c];
            bus.shim_wr_exokay = (c != 1);
            bus.p_wr_rdy       = WR_RDY[c];
            rsp_q.push_back('{valid: WR_EV[c], rdy: WR_ER[c], data: 64'(c != 1)});
            #1;
            rsp_exp = (rsp_q.size() != 0) ? rsp_q.pop_front() : '1;
            checks++;
            if (bus.p_wr_valid !== rsp_exp.valid || bus.shim_wr_rdy !== rsp_exp.rdy ||
                bus.p_wr_exokay !== rsp_exp.data[0] || bus.p_rd_valid !== 3'b000) begin
                fails++;
                $display("FAIL wr_route: got valid=%b rdy=%b exokay=%b expected valid=%b rdy=%b exokay=%b",
                         bus.p_wr_valid, bus.shim_wr_rdy, bus.p_wr_exokay, rsp_exp.valid,
                         rsp_exp.rdy, rsp_exp.data[0]);
            end
            $display("B beat: id %0d valid %b rdy %b", WR_ID[c], bus.p_wr_valid, bus.shim_wr_rdy);
        end
        @(negedge clk);
        bus.shim_wr_valid = 1'b0;
        bus.p_rd_rdy      = '0;
        bus.p_wr_rdy      = '0;
    endtask

    task automatic test_reset_locked();
        @(negedge clk);
        bus.p_wr_req    = 3'b001;
        bus.shim_wr_gnt = 1'b1;
        exp_wr_q.push_back(0);
        #1;
        exp_gnt = (exp_wr_q.size() != 0) ? 3'(1 << exp_wr_q.pop_front()) : 3'b111;
        checks++;
        if (bus.p_wr_gnt !== exp_gnt) begin
            fails++; $display("FAIL pre_gnt: got %b expected %b", bus.p_wr_gnt, exp_gnt);
        end
        @(negedge clk);
        bus.p_wr_req    = 3'b010;
        bus.shim_wr_gnt = 1'b0;
        @(negedge clk);
        bus.p_wr_req = 3'b011;
        #1;
        checks++;
        if (bus.shim_wr_id !== 4'd1 || bus.p_wr_gnt !== 3'b000) begin
            fails++;
            $display("FAIL locked_port1: got id=%0d gnt=%b expected id=1 gnt=000", bus.shim_wr_id,
                     bus.p_wr_gnt);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.shim_wr_id !== 4'd0 || bus.p_wr_gnt !== 3'b000) begin
            fails++;
            $display("FAIL async_reset: got id=%0d gnt=%b expected id=0 gnt=000", bus.shim_wr_id,
                     bus.p_wr_gnt);
        end
        @(negedge clk);
        rst_n           = 1'b1;
        bus.shim_wr_gnt = 1'b1;
        exp_wr_q.push_back(0);
        #1;
        exp_gnt = (exp_wr_q.size() != 0) ? 3'(1 << exp_wr_q.pop_front()) : 3'b111;
        checks++;
        if (bus.p_wr_gnt !== exp_gnt) begin
            fails++; $display("FAIL post_reset_gnt: got %b expected %b", bus.p_wr_gnt, exp_gnt);
        end
        $display("write grant after reset: gnt %b", bus.p_wr_gnt);
        @(negedge clk);
        bus.p_wr_req    = '0;
        bus.shim_wr_gnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_writes();
        test_locked_burst();
        test_read_routing();
        test_reset_locked();
        checks++;
        if (exp_rd_q.size() + exp_wr_q.size() + rsp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0",
                     exp_rd_q.size() + exp_wr_q.size() + rsp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
